// File: rtl/hs_npu_csr_master.sv
// hs_npu_csr_master: turns single CSR commands into AXI4-lite transactions.
// Only one transaction is in flight at a time. A per-transaction cycle counter
// aborts a stalled transaction and reports it as a timed-out SLVERR.
//
// Handshake rule for every channel (cmd, aw, w, b, ar, r): a transfer happens
// on a rising clk edge where valid && ready are both high. Once raised, a
// valid and its payload stay unchanged until that transfer. The only
// exception is a timeout abort, which drops the valid. Ready signals are
// plain level indications and never depend on the matching valid.
module hs_npu_csr_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [2:0]  PROT           = 3'b010
) (
   input  logic        clk,
   input  logic        rst_n,
   // command side
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   // response side
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,
   // AXI4-lite write address
   output logic        csr_awvalid,
   input  logic        csr_awready,
   output logic [31:0] csr_awaddr,
   output logic [2:0]  csr_awprot,
   // AXI4-lite write data
   output logic        csr_wvalid,
   input  logic        csr_wready,
   output logic [31:0] csr_wdata,
   output logic [3:0]  csr_wstrb,
   // AXI4-lite write response
   input  logic        csr_bvalid,
   output logic        csr_bready,
   input  logic [1:0]  csr_bresp,
   // AXI4-lite read address
   output logic        csr_arvalid,
   input  logic        csr_arready,
   output logic [31:0] csr_araddr,
   output logic [2:0]  csr_arprot,
   // AXI4-lite read data
   input  logic        csr_rvalid,
   output logic        csr_rready,
   input  logic [31:0] csr_rdata,
   input  logic [1:0]  csr_rresp,
   // current FSM state, for observation only
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WADDR = 3'd1,
      S_WRESP = 3'd2,
      S_RADDR = 3'd3,
      S_RDATA = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        run_q;      // low during reset so cmd_ready stays 0 until a clock after release
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_pend_q;
   logic        w_pend_q;
   logic [15:0] cnt_q;
   logic [31:0] rdata_q;
   logic [1:0]  resp_q;
   logic        to_q;

   logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, expired, abort;

   assign accept  = cmd_valid   && cmd_ready;
   assign aw_hs   = csr_awvalid && csr_awready;
   assign w_hs    = csr_wvalid  && csr_wready;
   assign b_hs    = csr_bvalid  && csr_bready;
   assign ar_hs   = csr_arvalid && csr_arready;
   assign r_hs    = csr_rvalid  && csr_rready;
   assign expired = (cnt_q == TO_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; abort marks a timeout-driven exit to DONE.
   // In the response states a completing handshake beats the timeout so a
   // response the slave has already delivered is never discarded.
   always_comb begin
      state_d = state_q;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = cmd_write ? S_WADDR : S_RADDR;
         end
         S_WADDR: begin
            if (expired) begin
               abort   = 1'b1;
               state_d = S_DONE;
            end else if ((!aw_pend_q || aw_hs) && (!w_pend_q || w_hs)) begin
               state_d = S_WRESP;
            end
         end
         S_WRESP: begin
            if (b_hs) state_d = S_DONE;
            else if (expired) begin
               abort   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_RADDR: begin
            if (expired) begin
               abort   = 1'b1;
               state_d = S_DONE;
            end else if (ar_hs) begin
               state_d = S_RDATA;
            end
         end
         S_RDATA: begin
            if (r_hs) state_d = S_DONE;
            else if (expired) begin
               abort   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Command capture and per-channel pending flags for the write address/data pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (accept) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_pend_q <= cmd_write;
            w_pend_q  <= cmd_write;
         end else if (state_q == S_WADDR) begin
            if (aw_hs || abort) aw_pend_q <= 1'b0;
            if (w_hs  || abort) w_pend_q  <= 1'b0;
         end
      end
   end

   // Transaction age counter: zero on accept, counts every busy cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt_q <= '0;
      else if (accept)            cnt_q <= '0;
      else if (state_q != S_IDLE) cnt_q <= cnt_q + 16'd1;
   end

   // Response capture: slave response on b/r handshake, SLVERR with zero data on abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         resp_q  <= '0;
         to_q    <= 1'b0;
      end else if (accept) begin
         rdata_q <= '0;
         resp_q  <= '0;
         to_q    <= 1'b0;
      end else if (abort) begin
         rdata_q <= '0;
         resp_q  <= 2'b10;
         to_q    <= 1'b1;
      end else if (state_q == S_WRESP && b_hs) begin
         rdata_q <= '0;
         resp_q  <= csr_bresp;
         to_q    <= 1'b0;
      end else if (state_q == S_RDATA && r_hs) begin
         rdata_q <= csr_rdata;
         resp_q  <= csr_rresp;
         to_q    <= 1'b0;
      end
   end

   assign cmd_ready   = run_q && (state_q == S_IDLE);
   assign csr_awvalid = (state_q == S_WADDR) && aw_pend_q;
   assign csr_wvalid  = (state_q == S_WADDR) && w_pend_q;
   assign csr_bready  = (state_q == S_WRESP);
   assign csr_arvalid = (state_q == S_RADDR);
   assign csr_rready  = (state_q == S_RDATA);
   assign csr_awaddr  = addr_q;
   assign csr_araddr  = addr_q;
   assign csr_wdata   = wdata_q;
   assign csr_wstrb   = wstrb_q;
   assign csr_awprot  = PROT;
   assign csr_arprot  = PROT;
   assign rsp_valid   = (state_q == S_DONE);
   assign rsp_rdata   = rdata_q;
   assign rsp_resp    = resp_q;
   assign rsp_timeout = to_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_hs_npu_csr_master.sv
// Directed bench for hs_npu_csr_master. Instance u_dut (TIMEOUT_CYCLES=16)
// covers the normal write/read flows and reset. Instance u_to
// (TIMEOUT_CYCLES=8) is fed by a slave that never responds, so every
// transaction it starts times out.
// Cycle numbering: the cycle in which a command is accepted is cycle 0. A
// write with a single-cycle slave gives rsp_valid in cycle 3, which is the
// fourth cycle counting the accept cycle.
module tb_hs_npu_csr_master;

   localparam logic [2:0] EXP_PROT = 3'b010;

   // clock / reset
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // shared command payload
   logic        cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;

   // main instance signals
   logic        cmd_valid, cmd_ready;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot, dbg_state;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   // timeout instance signals
   logic        cmd_valid_t, cmd_ready_t;
   logic        rsp_valid_t, rsp_timeout_t;
   logic [31:0] rsp_rdata_t;
   logic [1:0]  rsp_resp_t;
   logic        awvalid_t, wvalid_t, bready_t, arvalid_t, rready_t;
   logic [31:0] awaddr_t, wdata_t, araddr_t;
   logic [2:0]  awprot_t, arprot_t, dbg_state_t;
   logic [3:0]  wstrb_t;
   logic        zero1;
   logic [1:0]  zero2;
   logic [31:0] zero32;

   int checks = 0;
   int errors = 0;

   hs_npu_csr_master #(.TIMEOUT_CYCLES(16), .PROT(3'b010)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .rsp_timeout(rsp_timeout),
      .csr_awvalid(awvalid), .csr_awready(awready), .csr_awaddr(awaddr),
      .csr_awprot(awprot),
      .csr_wvalid(wvalid), .csr_wready(wready), .csr_wdata(wdata), .csr_wstrb(wstrb),
      .csr_bvalid(bvalid), .csr_bready(bready), .csr_bresp(bresp),
      .csr_arvalid(arvalid), .csr_arready(arready), .csr_araddr(araddr),
      .csr_arprot(arprot),
      .csr_rvalid(rvalid), .csr_rready(rready), .csr_rdata(rdata), .csr_rresp(rresp),
      .dbg_state(dbg_state)
   );

   hs_npu_csr_master #(.TIMEOUT_CYCLES(8), .PROT(3'b010)) u_to (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid_t), .rsp_rdata(rsp_rdata_t), .rsp_resp(rsp_resp_t),
      .rsp_timeout(rsp_timeout_t),
      .csr_awvalid(awvalid_t), .csr_awready(zero1), .csr_awaddr(awaddr_t),
      .csr_awprot(awprot_t),
      .csr_wvalid(wvalid_t), .csr_wready(zero1), .csr_wdata(wdata_t), .csr_wstrb(wstrb_t),
      .csr_bvalid(zero1), .csr_bready(bready_t), .csr_bresp(zero2),
      .csr_arvalid(arvalid_t), .csr_arready(zero1), .csr_araddr(araddr_t),
      .csr_arprot(arprot_t),
      .csr_rvalid(zero1), .csr_rready(rready_t), .csr_rdata(zero32), .csr_rresp(zero2),
      .dbg_state(dbg_state_t)
   );

   // driver: advance one clock, then settle 1 time unit past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard comparison
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 0; cmd_valid_t = 0; cmd_write = 0;
      cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      zero1 = 0; zero2 = '0; zero32 = '0;

      // ---------------- reset state
      #3;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_awvalid",   32'(awvalid),   32'd0);
      chk("rst_arvalid",   32'(arvalid),   32'd0);
      chk("rst_bready",    32'(bready),    32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_awprot",    32'(awprot),    32'(EXP_PROT));
      chk("rst_arprot",    32'(arprot),    32'(EXP_PROT));
      step();
      rst_n = 1'b1;
      chk("rel_cmd_ready_before_clk", 32'(cmd_ready), 32'd0);
      step();
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

      // ---------------- write 0x10 <- DEADBEEF, slave always ready
      awready = 1; wready = 1;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10;
      cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
      chk("w1_cmd_ready_c0", 32'(cmd_ready), 32'd1);
      step(); cmd_valid = 0;                     // cycle 1
      chk("w1_awvalid_c1", 32'(awvalid), 32'd1);
      chk("w1_wvalid_c1",  32'(wvalid),  32'd1);
      chk("w1_awaddr",     awaddr, 32'h10);
      chk("w1_wdata",      wdata, 32'hDEADBEEF);
      chk("w1_wstrb",      32'(wstrb), 32'hF);
      chk("w1_cmd_ready_c1", 32'(cmd_ready), 32'd0);
      step();                                    // cycle 2
      chk("w1_awvalid_c2", 32'(awvalid), 32'd0);
      chk("w1_wvalid_c2",  32'(wvalid),  32'd0);
      chk("w1_bready_c2",  32'(bready),  32'd1);
      chk("w1_rsp_valid_c2", 32'(rsp_valid), 32'd0);
      bvalid = 1; bresp = 2'b00;
      step(); bvalid = 0;                        // cycle 3
      chk("w1_rsp_valid_c3", 32'(rsp_valid), 32'd1);
      chk("w1_rsp_resp",     32'(rsp_resp),  32'd0);
      chk("w1_rsp_rdata",    rsp_rdata, 32'd0);
      chk("w1_rsp_timeout",  32'(rsp_timeout), 32'd0);
      chk("w1_bready_c3",    32'(bready), 32'd0);
      step();                                    // cycle 4
      chk("w1_rsp_valid_c4", 32'(rsp_valid), 32'd0);
      chk("w1_cmd_ready_c4", 32'(cmd_ready), 32'd1);

      // ---------------- read 0x04, arready after 3 cycles, rvalid after 5
      awready = 0; wready = 0;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h04;
      step(); cmd_valid = 0; cmd_addr = 32'hFFFF_FFFF;   // cycle 1
      for (int i = 1; i <= 3; i++) begin
         chk("r1_arvalid_wait", 32'(arvalid), 32'd1);
         chk("r1_araddr_wait",  araddr, 32'h04);
         chk("r1_rready_wait",  32'(rready), 32'd0);
         chk("r1_rdata_hold",   rsp_rdata, 32'd0);
         // stray rvalid while the address is still pending must be ignored
         rvalid = (i == 2); rdata = 32'hBAD0BAD0; rresp = 2'b10;
         step();
      end
      rvalid = 0;
      chk("r1_arvalid_c4", 32'(arvalid), 32'd1);           // cycle 4
      chk("r1_araddr_c4",  araddr, 32'h04);
      arready = 1;
      step(); arready = 0;                                   // cycle 5
      for (int i = 5; i <= 9; i++) begin
         chk("r1_arvalid_rdata", 32'(arvalid), 32'd0);
         chk("r1_rready_rdata",  32'(rready),  32'd1);
         chk("r1_rsp_valid_wait", 32'(rsp_valid), 32'd0);
         step();
      end
      chk("r1_rready_c10", 32'(rready), 32'd1);              // cycle 10
      rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
      step(); rvalid = 0; rdata = '0;                        // cycle 11
      chk("r1_rsp_valid",   32'(rsp_valid), 32'd1);
      chk("r1_rsp_rdata",   rsp_rdata, 32'h12345678);
      chk("r1_rsp_resp",    32'(rsp_resp), 32'd0);
      chk("r1_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("r1_rready_done", 32'(rready), 32'd0);
      step();
      chk("r1_rsp_valid_after", 32'(rsp_valid), 32'd0);

      // ---------------- write, W accepted two cycles before AW, bresp SLVERR
      awready = 0; wready = 1;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20;
      cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'h3;
      step(); cmd_valid = 0;                                 // cycle 1
      chk("w2_awvalid_c1", 32'(awvalid), 32'd1);
      chk("w2_wvalid_c1",  32'(wvalid),  32'd1);
      step(); wready = 0;                                    // cycle 2
      chk("w2_wvalid_c2",  32'(wvalid),  32'd0);
      chk("w2_awvalid_c2", 32'(awvalid), 32'd1);
      chk("w2_awaddr_c2",  awaddr, 32'h20);
      chk("w2_bready_c2",  32'(bready),  32'd0);
      step();                                                // cycle 3
      chk("w2_awvalid_c3", 32'(awvalid), 32'd1);
      chk("w2_bready_c3",  32'(bready),  32'd0);
      awready = 1;
      step(); awready = 0;                                   // cycle 4
      chk("w2_awvalid_c4", 32'(awvalid), 32'd0);
      chk("w2_bready_c4",  32'(bready),  32'd1);
      bvalid = 1; bresp = 2'b10;
      step(); bvalid = 0; bresp = 2'b00;                     // cycle 5
      chk("w2_rsp_valid",   32'(rsp_valid), 32'd1);
      chk("w2_rsp_resp",    32'(rsp_resp),  32'h2);
      chk("w2_rsp_rdata",   rsp_rdata, 32'd0);
      chk("w2_rsp_timeout", 32'(rsp_timeout), 32'd0);
      step();

      // ---------------- timeout: read with arready never asserted (TIMEOUT_CYCLES=8)
      cmd_valid_t = 1; cmd_write = 0; cmd_addr = 32'h30;
      chk("to_cmd_ready_c0", 32'(cmd_ready_t), 32'd1);
      step(); cmd_valid_t = 0;                               // cycle 1
      for (int i = 1; i <= 8; i++) begin
         chk("to_arvalid_held", 32'(arvalid_t), 32'd1);
         chk("to_rsp_valid_wait", 32'(rsp_valid_t), 32'd0);
         step();
      end
      chk("to_arvalid_c9",   32'(arvalid_t), 32'd0);         // cycle 9
      chk("to_rready_c9",    32'(rready_t),  32'd0);
      chk("to_rsp_valid",    32'(rsp_valid_t), 32'd1);
      chk("to_rsp_timeout",  32'(rsp_timeout_t), 32'd1);
      chk("to_rsp_resp",     32'(rsp_resp_t), 32'h2);
      chk("to_rsp_rdata",    rsp_rdata_t, 32'd0);
      step();                                                // cycle 10
      chk("to_rsp_valid_c10", 32'(rsp_valid_t), 32'd0);
      chk("to_cmd_ready_c10", 32'(cmd_ready_t), 32'd1);
      cmd_valid_t = 1; cmd_addr = 32'h34;
      step(); cmd_valid_t = 0;
      chk("to_next_cmd_ready", 32'(cmd_ready_t), 32'd0);
      chk("to_next_arvalid",   32'(arvalid_t),   32'd1);
      chk("to_next_araddr",    araddr_t, 32'h34);

      // ---------------- reset asserted while in WRESP
      awready = 1; wready = 1;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40;
      cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
      step(); cmd_valid = 0;                                 // cycle 1
      step();                                                // cycle 2 (WRESP)
      chk("rw_bready_before", 32'(bready), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_bready",    32'(bready),    32'd0);
      chk("rw_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rw_awaddr",    awaddr, 32'd0);
      chk("rw_wdata",     wdata,  32'd0);
      chk("rw_rsp_resp",  32'(rsp_resp), 32'd0);
      chk("rw_awprot",    32'(awprot), 32'(EXP_PROT));
      chk("rw_to_arvalid", 32'(arvalid_t), 32'd0);
      step();
      rst_n = 1'b1;
      chk("rw_cmd_ready_release", 32'(cmd_ready), 32'd0);
      step();
      chk("rw_cmd_ready_clk", 32'(cmd_ready), 32'd1);
      awready = 0; wready = 0; arready = 1;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h08;
      step(); cmd_valid = 0;                                 // cycle 1
      chk("rr_arvalid", 32'(arvalid), 32'd1);
      chk("rr_araddr",  araddr, 32'h08);
      step(); arready = 0;                                   // cycle 2
      chk("rr_rready", 32'(rready), 32'd1);
      rvalid = 1; rdata = 32'hA5A50F0F; rresp = 2'b00;
      step(); rvalid = 0;                                    // cycle 3
      chk("rr_rsp_valid",   32'(rsp_valid), 32'd1);
      chk("rr_rsp_rdata",   rsp_rdata, 32'hA5A50F0F);
      chk("rr_rsp_resp",    32'(rsp_resp), 32'd0);
      chk("rr_rsp_timeout", 32'(rsp_timeout), 32'd0);
      step();

      // ---------------- report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hs_npu_csr_master.md
HS_NPU_CSR_MASTER -- requirements
Module: hs_npu_csr_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles allowed per transaction before abort; legal range 2..65535.
REQ-002 SHALL have parameter PROT, default 3'b010: value driven on csr_awprot and csr_arprot.
REQ-003 SHALL have port clk input 1: the block's single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n input 1: reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid input 1: a command is offered.
REQ-006 SHALL have port cmd_ready output 1: the block accepts a command.
REQ-007 SHALL have port cmd_write input 1: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr input 32: CSR byte address.
REQ-009 SHALL have port cmd_wdata input 32: write data.
REQ-010 SHALL have port cmd_wstrb input 4: write byte strobes.
REQ-011 SHALL have port rsp_valid output 1: one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata output 32: read data; 0 for writes and for timeouts.
REQ-013 SHALL have port rsp_resp output 2: BRESP or RRESP of the completed transaction.
REQ-014 SHALL have port rsp_timeout output 1: transaction aborted by timeout.
REQ-015 SHALL have port csr_awvalid output 1: AXI4-lite write-address valid.
REQ-016 SHALL have port csr_awready input 1: write-address ready.
REQ-017 SHALL have port csr_awaddr output 32: write address.
REQ-018 SHALL have port csr_awprot output 3: equals PROT.
REQ-019 SHALL have port csr_wvalid output 1: write-data valid.
REQ-020 SHALL have port csr_wready input 1: write-data ready.
REQ-021 SHALL have port csr_wdata output 32: write data.
REQ-022 SHALL have port csr_wstrb output 4: write strobes.
REQ-023 SHALL have port csr_bvalid input 1: write-response valid.
REQ-024 SHALL have port csr_bready output 1: write-response ready.
REQ-025 SHALL have port csr_bresp input 2: write response.
REQ-026 SHALL have port csr_arvalid output 1: read-address valid.
REQ-027 SHALL have port csr_arready input 1: read-address ready.
REQ-028 SHALL have port csr_araddr output 32: read address.
REQ-029 SHALL have port csr_arprot output 3: equals PROT.
REQ-030 SHALL have port csr_rvalid input 1: read-data valid.
REQ-031 SHALL have port csr_rready output 1: read-data ready.
REQ-032 SHALL have port csr_rdata input 32: read data.
REQ-033 SHALL have port csr_rresp input 2: read response.

Function
REQ-034 SHALL implement the states IDLE, WADDR (AW and W outstanding), WRESP, RADDR, RDATA and DONE, with at most one transaction outstanding.
REQ-035 SHALL assert cmd_ready only in IDLE; the handshake cmd_valid&&cmd_ready registers addr, wdata and wstrb and moves to WADDR (cmd_write=1) or RADDR (cmd_write=0).
REQ-036 SHALL, in WADDR, assert csr_awvalid and csr_wvalid from the next cycle and drop each independently on its own handshake; when both have completed (same cycle or any order) the block moves to WRESP.
REQ-037 SHALL hold every AXI payload stable while its valid is high, and SHALL never drop a valid before its handshake except on timeout.
REQ-038 SHALL assert csr_bready only in WRESP and csr_rready only in RDATA; on handshake it captures the response (and rdata for reads) and moves to DONE.
REQ-039 SHALL, in RADDR, assert csr_arvalid until the handshake and then move to RDATA.
REQ-040 SHALL, in DONE, pulse rsp_valid for exactly one cycle with rsp_timeout=0 and then return to IDLE; minimum command-to-rsp_valid latency is 4 cycles when the slave is always ready.
REQ-041 SHALL run a 16-bit timeout counter that clears on command accept and increments every non-IDLE cycle; when it reaches TIMEOUT_CYCLES-1, all valids/readies deassert the next cycle and DONE issues rsp_valid with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-042 SHALL ignore csr_bvalid/csr_rvalid arriving outside WRESP/RDATA (no capture, no state change).

Reset
REQ-043 SHALL, while rst_n=0 (also mid-transaction), force IDLE, all outputs 0 except awprot/arprot=PROT, clear the counter and captured data; cmd_ready=1 from the first clock after release.

Verification
REQ-044 Write 0x10<-0xDEADBEEF, strb 0xF, slave always ready, bresp 0 -> AW/W single-cycle handshakes, rsp_valid one cycle at +4, rsp_resp 0.
REQ-045 Read 0x04, slave returns 0x12345678 after 3-cycle arready and 5-cycle rvalid delays -> rsp_rdata 0x12345678, rsp_resp 0, valids stable throughout.
REQ-046 Write with wready 2 cycles before awready, then bresp 2'b10 -> WRESP entered only after both handshakes, rsp_resp 2'b10.
REQ-047 TIMEOUT_CYCLES=8, read with arready never asserted -> arvalid drops after 8 cycles, rsp_timeout=1, rsp_resp 2'b10, rsp_rdata 0, next command accepted.
REQ-048 rst_n asserted in WRESP -> all outputs 0 asynchronously; after release a read completes normally.
